// File: rtl/sprite_load_scheduler_pkg.sv
// Shared types and width defaults for the sprite ROM load scheduler and its neighbours.
// No logic; elaboration-time constants and a width helper only.
// No flow control; consumers import what they need.
package sprite_load_scheduler_pkg;

    // Row and code widths the renderer, ROM and scheduler must agree on.
    localparam int ROW_W_DEF  = 4;
    localparam int CODE_W_DEF = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PICK = 2'd1,
        ST_HOLD = 2'd2
    } sched_state_e;

    // Index width for n renderers; a single renderer still needs one bit.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sprite_load_scheduler_if.sv
// Bundle of signals between the hvsync/renderer side and the ROM load scheduler.
// Pure wiring; no latency.
// No backpressure; load pulses are fire-and-forget.
interface sprite_load_scheduler_if
    import sprite_load_scheduler_pkg::*;
#(
    parameter int NUM_SPRITES = 4,
    parameter int ROW_W       = ROW_W_DEF,
    parameter int CODE_W      = CODE_W_DEF
);
    logic                          hsync;
    logic [NUM_SPRITES-1:0]        in_progress;
    logic [NUM_SPRITES*ROW_W-1:0]  row_addr;
    logic [NUM_SPRITES*CODE_W-1:0] sprite_code;
    logic [NUM_SPRITES-1:0]        load;
    logic [CODE_W+ROW_W-1:0]       rom_addr;
    logic                          busy;
    logic                          overrun;

    // Renderer bank / hvsync side.
    modport master (
        output hsync, in_progress, row_addr, sprite_code,
        input  load, rom_addr, busy, overrun
    );

    // Scheduler side.
    modport slave (
        input  hsync, in_progress, row_addr, sprite_code,
        output load, rom_addr, busy, overrun
    );
endinterface

// File: rtl/sprite_slot_picker.sv
// Lowest-set-bit picker: returns index and one-hot of the lowest pending renderer.
// Purely combinational, zero latency.
// No backpressure; an empty mask yields index 0 and an all-zero one-hot.
module sprite_slot_picker #(
    parameter int N     = 4,
    parameter int SEL_W = 2
) (
    input  logic [N-1:0]     mask_i,
    output logic [SEL_W-1:0] idx_o,
    output logic [N-1:0]     onehot_o
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        idx_o    = '0;
        onehot_o = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (mask_i[i]) begin
                idx_o       = SEL_W'(i);
                onehot_o    = '0;
                onehot_o[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sprite_load_scheduler.sv
// Time-shares one sprite ROM among renderers during hsync: one load pulse + exclusive slot each.
// Load appears the cycle after PICK; each renderer costs SLOT_CYCLES+1 cycles of schedule.
// No backpressure; a window that closes early drops the rest of the line and sets sticky overrun.
module sprite_load_scheduler
    import sprite_load_scheduler_pkg::*;
#(
    parameter int NUM_SPRITES = 4,
    parameter int ROW_W       = ROW_W_DEF,
    parameter int CODE_W      = CODE_W_DEF,
    parameter int SLOT_CYCLES = 4          // HOLD cycles per grant, load cycle included; >= 3
) (
    input  logic                    clk,
    input  logic                    reset,
    sprite_load_scheduler_if.slave  bus
);

    localparam int SEL_W = sel_width(NUM_SPRITES);
    localparam int CNT_W = $clog2(SLOT_CYCLES + 1);

    sched_state_e           state_q;
    logic [NUM_SPRITES-1:0] pending_q;
    logic [SEL_W-1:0]       sel_q;
    logic [NUM_SPRITES-1:0] load_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   overrun_q;
    logic                   hsync_q;

    logic [SEL_W-1:0]        pick_idx;
    logic [NUM_SPRITES-1:0]  pick_onehot;
    logic                    hsync_rise;
    logic                    window_lost;
    logic                    slot_done;
    logic [CODE_W+ROW_W-1:0] rom_addr_mux;

    sprite_slot_picker #(
        .N     (NUM_SPRITES),
        .SEL_W (SEL_W)
    ) u_picker (
        .mask_i   (pending_q),
        .idx_o    (pick_idx),
        .onehot_o (pick_onehot)
    );

    assign hsync_rise  = bus.hsync & ~hsync_q;
    // Window closed while renderers are still waiting: the line cannot be completed.
    assign window_lost = ~bus.hsync & (|pending_q);
    assign slot_done   = (cnt_q == CNT_W'(SLOT_CYCLES));

    // Schedule FSM: capture on hsync rise, then PICK/HOLD each pending renderer in index order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            pending_q <= '0;
            sel_q     <= '0;
            load_q    <= '0;
            cnt_q     <= '0;
            overrun_q <= 1'b0;
            hsync_q   <= 1'b0;
        end else begin
            hsync_q <= bus.hsync;
            load_q  <= '0;
            unique case (state_q)
                ST_IDLE: begin
                    // A rise seen while busy is simply lost; only IDLE captures.
                    if (hsync_rise) begin
                        pending_q <= bus.in_progress;
                        if (|bus.in_progress) begin
                            state_q <= ST_PICK;
                        end
                    end
                end
                ST_PICK: begin
                    // No slot is open yet, so a lost window abandons the line outright.
                    if (window_lost) begin
                        overrun_q <= 1'b1;
                        pending_q <= '0;
                        state_q   <= ST_IDLE;
                    end else begin
                        sel_q     <= pick_idx;
                        pending_q <= pending_q & ~pick_onehot;
                        load_q    <= pick_onehot;
                        cnt_q     <= CNT_W'(1);
                        state_q   <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    cnt_q <= cnt_q + 1'b1;
                    // The renderer holding the ROM keeps its slot; only the waiters are dropped.
                    if (window_lost) begin
                        overrun_q <= 1'b1;
                        pending_q <= '0;
                    end
                    if (slot_done) begin
                        state_q <= ((|pending_q) && !window_lost) ? ST_PICK : ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // ROM address follows the registered grant so it is stable for the whole slot.
    always_comb begin
        rom_addr_mux = '0;
        for (int i = 0; i < NUM_SPRITES; i++) begin
            if (sel_q == SEL_W'(i)) begin
                rom_addr_mux = {bus.sprite_code[i*CODE_W +: CODE_W], bus.row_addr[i*ROW_W +: ROW_W]};
            end
        end
    end

    assign bus.load     = load_q;
    assign bus.rom_addr = rom_addr_mux;
    assign bus.busy     = (state_q != ST_IDLE);
    assign bus.overrun  = overrun_q;

endmodule
